siso_serial_arbiter: RTL and testbench
======================================

Name: siso_serial_arbiter

Overview:
- Two-requester front end for the team's serial-in/serial-out shift lane.
- Accepts parallel words from two clients over valid/ready and arbitrates round-robin.
- Shifts the granted word out MSB first, one bit per clock, on a single serial line.
- Provides frame valid, owner ID, busy and done status; enforces a configurable idle gap between frames.

Parameters:
- bits, 8, word width and frame length in clock cycles (>=2)
- GAP, 2, idle cycles inserted after each frame before the next grant (>=0)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req0_valid  input  1  requester 0 has a word
- req0_data  input  bits  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when valid & ready
- req1_valid  input  1  requester 1 has a word
- req1_data  input  bits  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle when valid & ready
- s_out  output  1  serial data, MSB first
- s_valid  output  1  s_out carries a frame bit
- s_owner  output  1  requester ID of the current/last frame
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after a frame's last bit

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - Round-robin pointer set to req0.
  - All outputs 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Grant = pointer requester if its valid=1, else the other requester if its valid=1.
  - reqN_ready = (state==IDLE) & grantN. Combinational from state, pointer and valids; at most one ready high.
  - On accept edge: load reqN_data into shift register; s_owner<=N; bit counter<=0; pointer<=other requester; state->SHIFT.
  - No valid: stay IDLE; pointer unchanged.
- SHIFT:
  - s_valid=1; s_out=shift_reg[bits-1].
  - Each edge: shift left with zero fill; counter increments.
  - Edge at counter==bits-1 (last bit): state->GAP if GAP>0, else IDLE; done<=1 for the following cycle.
  - Frame occupies exactly bits cycles.
- GAP:
  - s_valid=0, s_out=0.
  - Counts GAP cycles, then state->IDLE.
- Latency:
  - Accept at edge N; MSB on s_out in cycle N..N+1; LSB in cycle N+bits-1..N+bits.
  - Minimum spacing from last bit of one frame to MSB of the next = GAP+1 cycles (GAP cycles plus one IDLE accept cycle).
- Outputs outside SHIFT: s_out=0 and s_valid=0.
- s_owner holds its value until the next accept.
- done: registered, exactly one cycle wide, coincides with the first GAP (or IDLE) cycle.
- busy=1 in SHIFT and GAP.
- Valid rules:
  - Requesters hold valid and data stable until accepted.
  - Valid dropped before accept: request withdrawn, no effect.
  - reqN_data is sampled only on the accept edge; changes during SHIFT do not affect the frame.
- Simultaneous requests: pointer decides. After reset, req0 wins the first tie; thereafter grants alternate while both remain valid.
- Single persistent requester: served every frame even though the pointer points away.
- Reset mid-frame: frame aborted immediately (asynchronous); no done pulse; s_valid and s_out drop to 0; pointer returns to req0.
- All-ones and all-zeros words are legal. The serial stream has no framing; s_valid delimits frames.

Test Plan:
- Reset, then req0_data=8'b11001011 with valid → req0_ready high 1 cycle; s_out 1,1,0,0,1,0,1,1 over 8 cycles with s_valid=1; s_owner=0; done pulses 1 cycle after the LSB; busy drops after 2 GAP cycles.
- Both valid after reset, req0=8'hA5, req1=8'h3C → frames A5 (owner 0) then 3C (owner 1); s_valid low exactly 3 cycles between them.
- Both held valid for 4 frames → owners alternate 0,1,0,1; with only req1 valid for 2 frames → owner 1 twice.
- Assert rst=0 for 1 cycle at bit 4 of frame 8'hFF → s_valid and s_out go 0 asynchronously; no done pulse; next tie grants req0.
- GAP=0 instance, req0 sends 8'h81 and 8'h7E back-to-back → s_valid low exactly 1 cycle between frames; bit sequences exact.
- req1_valid pulsed 1 cycle during SHIFT and dropped → never granted, req1_ready never high, no extra frame.

Source files
------------

// File: rtl/siso_serial_arbiter.sv
// Two-client round-robin front end for the serial shift lane.
// Granted word goes out MSB first, followed by a fixed idle gap.
module siso_serial_arbiter #(
    parameter int bits = 8,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [bits-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [bits-1:0] req1_data,
    output logic            req1_ready,
    output logic            s_out,
    output logic            s_valid,
    output logic            s_owner,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(bits);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(bits - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [bits-1:0] shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic            done_q, done_d;

    logic idle;
    logic grant0;
    logic grant1;

    assign idle = (state_q == ST_IDLE);

    // Pointer requester has priority; the other wins only when it is alone.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!ptr_q) begin
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
        end else begin
            grant1 = req1_valid;
            grant0 = req0_valid & ~req1_valid;
        end
    end

    assign req0_ready = rst & idle & grant0;
    assign req1_ready = rst & idle & grant1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    shift_d = grant1 ? req1_data : req0_data;
                    owner_d = grant1;
                    ptr_d   = ~grant1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[bits-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            done_q  <= done_d;
        end
    end

    assign s_valid = (state_q == ST_SHIFT);
    assign s_out   = s_valid & shift_q[bits-1];
    assign s_owner = owner_q;
    assign busy    = ~idle;
    assign done    = done_q;

endmodule

// File: tb/tb_siso_serial_arbiter.sv
// Scoreboard bench for siso_serial_arbiter (GAP=2 and GAP=0 instances).
// Stimulus pushes expected frames; a negedge monitor rebuilds and compares them.
module tb_siso_serial_arbiter;

    typedef struct {
        logic [7:0] d;
        logic       o;
        int         gap;
    } exp_t;

    logic clk;
    logic rst;

    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       s_out, s_valid, s_owner, busy, done;

    logic       b_v0, b_v1;
    logic [7:0] b_d0, b_d1;
    logic       b_r0, b_r1;
    logic       b_out, b_valid, b_owner, b_busy, b_done;

    int total = 0;
    int bad   = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic [7:0] cur[2];
    int  nb[2];
    int  low[2];
    bit  dexp[2];

    siso_serial_arbiter #(.bits(8), .GAP(2)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .s_out(s_out), .s_valid(s_valid), .s_owner(s_owner),
        .busy(busy), .done(done)
    );

    siso_serial_arbiter #(.bits(8), .GAP(0)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .s_out(b_out), .s_valid(b_valid), .s_owner(b_owner),
        .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d,
                        input logic o, input int g);
        exp_t e;
        e.d = d;
        e.o = o;
        e.gap = g;
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic mon(input int k, input logic sv, input logic so,
                       input logic own, input logic dn);
        exp_t e;
        bit   have;
        if (!rst) begin
            nb[k]   = 0;
            dexp[k] = 0;
            low[k]  = -1000;
            return;
        end
        if (dexp[k] || dn) chk($sformatf("done%0d", k), dn, dexp[k]);
        dexp[k] = 0;
        if (sv) begin
            cur[k] = {cur[k][6:0], so};
            nb[k]++;
            if (nb[k] == 8) begin
                have = (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                chk($sformatf("frame_expected%0d", k), int'(have), 1);
                if (have) begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("data%0d", k), cur[k], e.d);
                    chk($sformatf("owner%0d", k), own, e.o);
                    if (e.gap >= 0)
                        chk($sformatf("gap%0d", k), low[k], e.gap);
                end
                nb[k]   = 0;
                low[k]  = 0;
                dexp[k] = 1;
            end
        end else begin
            chk($sformatf("sout_idle%0d", k), so, 0);
            low[k]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, s_valid, s_out, s_owner, done);
        mon(1, b_valid, b_out, b_owner, b_done);
    end

    task automatic serve(input int budget);
        int r0 = 0;
        int r1 = 0;
        int n0 = q0.size();
        int n1 = q1.size();
        int cyc = 0;
        bit fin = 0;
        while (!fin) begin
            @(negedge clk);
            req0_valid = (q0.size() != 0);
            req1_valid = (q1.size() != 0);
            if (req0_valid) req0_data = q0[0];
            if (req1_valid) req1_data = q1[0];
            #1;
            chk("ready_excl", int'(req0_ready & req1_ready), 0);
            if (req0_ready) begin
                r0++;
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (req1_ready) begin
                r1++;
                if (q1.size() != 0) void'(q1.pop_front());
            end
            cyc++;
            if (!req0_valid && !req1_valid && !busy) fin = 1;
            if (cyc > budget) begin
                chk("serve_timeout", cyc, budget);
                fin = 1;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rdy0_count", r0, n0);
        chk("rdy1_count", r1, n1);
        chk("sb_empty", sb0.size(), 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int t;
        int cnt;
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_data = 0;  req1_data = 0;
        b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0;
        for (int k = 0; k < 2; k++) begin
            cur[k] = 0; nb[k] = 0; low[k] = -1000; dexp[k] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_svalid", s_valid, 0);
        chk("rst_sout", s_out, 0);
        chk("rst_owner", s_owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", int'(req0_ready | req1_ready), 0);
        rst = 1'b1;

        // single word 11001011 from req0, then done/busy timing
        q0 = '{8'hCB};
        push(0, 8'hCB, 1'b0, -1);
        fork
            serve(200);
            begin
                t = 0;
                @(negedge clk);
                while (!done && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("done_seen", done, 1);
                chk("busy_gap1", busy, 1);
                @(negedge clk);
                chk("done_width", done, 0);
                chk("busy_gap2", busy, 1);
                @(negedge clk);
                chk("busy_idle", busy, 0);
            end
        join

        // tie right after reset: req0 first, then req1 after 3 idle cycles
        rst_pulse();
        q0 = '{8'hA5};
        q1 = '{8'h3C};
        push(0, 8'hA5, 1'b0, -1);
        push(0, 8'h3C, 1'b1, 3);
        serve(200);

        // both held for four frames: owners alternate
        q0 = '{8'h11, 8'h22};
        q1 = '{8'h33, 8'h44};
        push(0, 8'h11, 1'b0, -1);
        push(0, 8'h33, 1'b1, 3);
        push(0, 8'h22, 1'b0, 3);
        push(0, 8'h44, 1'b1, 3);
        serve(400);

        // req1 alone is served twice in a row
        q1 = '{8'h55, 8'h66};
        push(0, 8'h55, 1'b1, -1);
        push(0, 8'h66, 1'b1, 3);
        serve(200);

        // abort frame FF at bit 4 with an asynchronous reset
        @(negedge clk);
        req0_valid = 1; req0_data = 8'hFF;
        #1 chk("abort_ready", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        repeat (4) @(posedge clk);
        #2 chk("abort_pre_valid", s_valid, 1);
        rst = 1'b0;
        #1;
        chk("abort_svalid", s_valid, 0);
        chk("abort_sout", s_out, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(done);
        end
        chk("abort_no_done", cnt, 0);
        q0 = '{8'h5A};
        q1 = '{8'hC3};
        push(0, 8'h5A, 1'b0, -1);
        push(0, 8'hC3, 1'b1, 3);
        serve(200);

        // req1 pulses for one cycle during a frame and withdraws
        push(0, 8'h96, 1'b0, -1);
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h96;
        #1 chk("wd_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1; req1_data = 8'hEE;
        #1 chk("wd_ready1_pulse", req1_ready, 0);
        @(negedge clk);
        req1_valid = 0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            #1 cnt += int'(req1_ready);
        end
        chk("wd_ready1_never", cnt, 0);
        chk("wd_sb_empty", sb0.size(), 0);

        // GAP=0 instance: back-to-back 81 then 7E from req0
        push(1, 8'h81, 1'b0, -1);
        push(1, 8'h7E, 1'b0, 1);
        @(negedge clk);
        b_v0 = 1; b_d0 = 8'h81;
        t = 0;
        #1;
        while (!b_r0 && t < 30) begin
            @(negedge clk);
            #1 t++;
        end
        chk("b_ready_first", b_r0, 1);
        @(negedge clk);
        b_d0 = 8'h7E;
        t = 0;
        #1;
        while (!b_r0 && t < 30) begin
            @(negedge clk);
            #1 t++;
        end
        chk("b_ready_second", b_r0, 1);
        @(negedge clk);
        b_v0 = 0;
        repeat (15) @(negedge clk);
        chk("b_sb_empty", sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
